localbus_arbiter: RTL and testbench
===================================

LOCALBUS_ARBITER -- requirements
Module: localbus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1023, meaning the slave-ack wait limit in clk cycles (range 1..65535).
REQ-002 The block SHALL have parameter TO_DATA, default 32'hDEAD_BEEF, meaning the read data returned on timeout.
REQ-003 The block SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports m0_ale, m0_cs_n, m0_rd_wr  input  1 each  master 0 (host) localbus controls.
REQ-006 The block SHALL have port m0_data  input  32  master 0 address (on ale) / write data (while cs_n low).
REQ-007 The block SHALL have ports m0_ack_n  output  1 and m0_data_out  output  32  master 0 ack and read data.
REQ-008 The block SHALL have ports m1_ale, m1_cs_n, m1_rd_wr, m1_data, m1_ack_n, m1_data_out with the same widths and meanings for master 1 (internal config engine).
REQ-009 The block SHALL have ports ale, cs_n, rd_wr  output  1 each  downstream slave controls.
REQ-010 The block SHALL have port data  output  32  downstream address/write data.
REQ-011 The block SHALL have ports ack_n  input  1 and data_out  input  32  downstream slave ack and read data.
REQ-012 The block SHALL have port timeout_cnt  output  16  saturating count of timed-out transactions.
REQ-013 The block SHALL have port grant  output  2  one-hot owner of the current transaction; 2'b00 when idle.

Function
REQ-014 On mX_ale=1, the block SHALL latch mX_data and mX_rd_wr into a per-master request slot and set its pending flag on the next edge.
REQ-015 An mX_ale while that master's slot is pending or granted SHALL be ignored; the slot SHALL NOT be overwritten.
REQ-016 The FSM SHALL have states IDLE, ADDR, DATA, ACK, RELEASE, DRAIN.
REQ-017 IDLE: with no pending slot the FSM SHALL stay in IDLE; otherwise it SHALL grant one pending master, set grant, and go to ADDR.
REQ-018 Arbitration SHALL be round-robin: with one pending, grant it; with both pending, grant the master not granted last; after reset, master 0 wins the first tie.
REQ-019 ADDR: ale=1 for exactly one cycle, with data = latched address and rd_wr = latched rd_wr; the FSM SHALL then go to DATA.
REQ-020 Downstream ale SHALL first be high 2 cycles after the edge on which the master's ale is sampled, when the bus is idle.
REQ-021 DATA: once the granted master's cs_n is low, the block SHALL drive cs_n=0 and data = the granted master's mX_data (live), hold rd_wr, and start a cycle counter.
REQ-022 DATA: on ack_n=0, the block SHALL register data_out into the granted mX_data_out, drive mX_ack_n=0, and go to ACK.
REQ-023 DATA: if the counter reaches TIMEOUT with ack_n still 1, the block SHALL set mX_data_out=TO_DATA (writes: discarded), drive mX_ack_n=0, increment timeout_cnt (saturate at 16'hFFFF), and go to ACK.
REQ-024 ACK: the FSM SHALL go to RELEASE on the next cycle.
REQ-025 RELEASE: when the granted mX_cs_n=1, the block SHALL drive cs_n=1 and mX_ack_n=1 and go to DRAIN.
REQ-026 DRAIN: on ack_n=1, or after TIMEOUT cycles in DRAIN, the block SHALL clear the slot's pending flag, record the last grant, set grant=0, and go to IDLE.
REQ-027 The non-granted master's ack_n SHALL stay 1 and its data_out SHALL hold its value throughout; its ale SHALL still be latched per REQ-014.
REQ-028 When not driven by an active transaction, outputs SHALL idle at ale=0, cs_n=1, rd_wr=0, data=0.
REQ-029 Any undefined state SHALL go to IDLE.

Reset
REQ-030 While reset=1 on an edge, the block SHALL set: FSM=IDLE, pending flags=0, slots=0, last-grant=master 1, grant=0, ale=0, cs_n=1, rd_wr=0, data=0, m0/m1_ack_n=1, m0/m1_data_out=0, timeout_cnt=0, counter=0.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no ack issued; an ale on the edge where reset is high SHALL be lost.

Verification
REQ-032 Single read: m0 ale with data=32'h0080_0010, rd_wr=1, then cs_n=0; slave acks after 3 cycles with 32'h1234_5678 -> downstream ale seen 2 cycles after m0 ale; m0_data_out=32'h1234_5678, m0_ack_n=0, grant=2'b01.
REQ-033 Simultaneous ale on m0 and m1 after reset -> m0 served first, m1 second; a repeated tie then grants m1 first.
REQ-034 Write via m1: addr 32'h0000_3000, data 32'h0000_0055 -> downstream data=32'h0000_0055 while cs_n=0; m0 outputs unchanged.
REQ-035 Slave never acks, TIMEOUT=15 -> m0_ack_n=0 with m0_data_out=32'hDEAD_BEEF 15 cycles after cs_n falls; timeout_cnt=1.
REQ-036 Reset asserted in DATA -> next cycle cs_n=1, grant=0, ack_n outputs=1; a subsequent request completes normally.
REQ-037 m0 ale while m0 is granted -> ignored; the original address completes and no second transaction is issued.

Source files
------------

// File: rtl/localbus_arbiter.sv
// Two-master localbus arbiter: per-master request slots, round-robin grant,
// and a single downstream localbus with slave-ack timeout.

module localbus_arbiter_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        ale,
  input  logic        rd_wr,
  input  logic        block,
  input  logic        clr,
  input  logic [31:0] din,
  output logic        pend,
  output logic        rw,
  output logic [31:0] addr
);
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
      rw   <= 1'b0;
      addr <= '0;
    end else if (clr) begin
      pend <= 1'b0;
    end else if (ale && !block) begin
      pend <= 1'b1;
      rw   <= rd_wr;
      addr <= din;
    end
  end
endmodule

module localbus_arbiter #(
  parameter int          TIMEOUT = 1023,
  parameter logic [31:0] TO_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_ale,
  input  logic        m0_cs_n,
  input  logic        m0_rd_wr,
  input  logic [31:0] m0_data,
  output logic        m0_ack_n,
  output logic [31:0] m0_data_out,
  input  logic        m1_ale,
  input  logic        m1_cs_n,
  input  logic        m1_rd_wr,
  input  logic [31:0] m1_data,
  output logic        m1_ack_n,
  output logic [31:0] m1_data_out,
  output logic        ale,
  output logic        cs_n,
  output logic        rd_wr,
  output logic [31:0] data,
  input  logic        ack_n,
  input  logic [31:0] data_out,
  output logic [15:0] timeout_cnt,
  output logic [1:0]  grant
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_REL   = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [2:0]        state;
  logic              last;
  logic [15:0]       cnt;
  logic [1:0]        m_ale, m_cs_n, m_rw, pend, slot_rw, clr, m_ack_q;
  logic [1:0][31:0]  m_data, slot_addr, m_dout;
  logic              sel, win, done, gcs_n;
  logic [31:0]       gdata;

  assign m_ale  = {m1_ale, m0_ale};
  assign m_cs_n = {m1_cs_n, m0_cs_n};
  assign m_rw   = {m1_rd_wr, m0_rd_wr};
  assign m_data = {m1_data, m0_data};

  assign m0_ack_n    = m_ack_q[0];
  assign m1_ack_n    = m_ack_q[1];
  assign m0_data_out = m_dout[0];
  assign m1_data_out = m_dout[1];

  assign sel   = grant[1];
  assign gcs_n = m_cs_n[sel];
  assign gdata = m_data[sel];
  // On a tie the master that did not own the previous transaction wins.
  assign win   = (&pend) ? ~last : pend[1];
  assign done  = (state == S_DRAIN) && (ack_n || cnt == CNT_LAST);

  for (genvar g = 0; g < 2; g++) begin : g_slot
    assign clr[g] = done & grant[g];
    localbus_arbiter_slot u_slot (
      .clk   (clk),
      .reset (reset),
      .ale   (m_ale[g]),
      .rd_wr (m_rw[g]),
      .block (pend[g] | grant[g]),
      .clr   (clr[g]),
      .din   (m_data[g]),
      .pend  (pend[g]),
      .rw    (slot_rw[g]),
      .addr  (slot_addr[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      last        <= 1'b1;
      grant       <= 2'b00;
      cnt         <= '0;
      ale         <= 1'b0;
      cs_n        <= 1'b1;
      rd_wr       <= 1'b0;
      data        <= '0;
      m_ack_q     <= 2'b11;
      m_dout      <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|pend) begin
            grant <= win ? 2'b10 : 2'b01;
            state <= S_ADDR;
          end
        end
        S_ADDR: begin
          ale   <= 1'b1;
          data  <= slot_addr[sel];
          rd_wr <= slot_rw[sel];
          cnt   <= '0;
          state <= S_DATA;
        end
        S_DATA: begin
          ale <= 1'b0;
          if (cs_n) begin
            if (!gcs_n) begin
              cs_n <= 1'b0;
              data <= gdata;
              cnt  <= '0;
            end
          end else begin
            data <= gdata;
            if (!ack_n) begin
              m_dout[sel]  <= data_out;
              m_ack_q[sel] <= 1'b0;
              state        <= S_ACK;
            end else if (cnt == CNT_LAST) begin
              m_dout[sel]  <= TO_DATA;
              m_ack_q[sel] <= 1'b0;
              if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
              state        <= S_ACK;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_ACK: begin
          data  <= gdata;
          state <= S_REL;
        end
        S_REL: begin
          if (gcs_n) begin
            cs_n         <= 1'b1;
            rd_wr        <= 1'b0;
            data         <= '0;
            m_ack_q[sel] <= 1'b1;
            cnt          <= '0;
            state        <= S_DRAIN;
          end else begin
            data <= gdata;
          end
        end
        S_DRAIN: begin
          // Wait for the slave to drop ack, bounded so a stuck slave cannot wedge the bus.
          if (done) begin
            last  <= sel;
            grant <= 2'b00;
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= 2'b00;
          ale   <= 1'b0;
          cs_n  <= 1'b1;
          rd_wr <= 1'b0;
          data  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_localbus_arbiter.sv
// Bench for localbus_arbiter: master/slave BFMs, scenario tasks and a
// randomized round-robin/memory reference model.

module tb_localbus_arbiter;
  localparam int          TO    = 15;
  localparam logic [31:0] TOD   = 32'hDEAD_BEEF;

  logic              clk = 1'b0, reset = 1'b1;
  logic [1:0]        m_ale = '0, m_cs_n = 2'b11, m_rw = '0;
  logic [1:0][31:0]  m_dat = '0;
  logic              m0_ack_n, m1_ack_n, ale, cs_n, rd_wr;
  logic [31:0]       m0_data_out, m1_data_out, data;
  logic              ack_n = 1'b1;
  logic [31:0]       data_out = '0;
  logic [15:0]       timeout_cnt;
  logic [1:0]        grant;

  int checks = 0, passes = 0, cyc = 0, slave_delay = 1;
  int ale_cyc[2];
  logic [31:0] lg_addr[$];
  logic        lg_rw[$];
  logic [1:0]  lg_gnt[$];
  int          lg_cyc[$];
  logic [31:0] smem[logic [31:0]];
  logic [31:0] mmem[logic [31:0]];

  localbus_arbiter #(.TIMEOUT(TO), .TO_DATA(TOD)) dut (
    .clk(clk), .reset(reset),
    .m0_ale(m_ale[0]), .m0_cs_n(m_cs_n[0]), .m0_rd_wr(m_rw[0]), .m0_data(m_dat[0]),
    .m0_ack_n(m0_ack_n), .m0_data_out(m0_data_out),
    .m1_ale(m_ale[1]), .m1_cs_n(m_cs_n[1]), .m1_rd_wr(m_rw[1]), .m1_data(m_dat[1]),
    .m1_ack_n(m1_ack_n), .m1_data_out(m1_data_out),
    .ale(ale), .cs_n(cs_n), .rd_wr(rd_wr), .data(data),
    .ack_n(ack_n), .data_out(data_out), .timeout_cnt(timeout_cnt), .grant(grant)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Downstream monitor: one log entry per address phase.
  initial forever begin
    @(negedge clk);
    if (ale === 1'b1) begin
      lg_addr.push_back(data); lg_rw.push_back(rd_wr);
      lg_gnt.push_back(grant); lg_cyc.push_back(cyc);
    end
  end

  // Slave: memory with ~addr default contents; slave_delay==0 means never ack.
  initial begin
    logic [31:0] s_addr;
    logic        s_rw, s_acked;
    int          s_cnt;
    s_addr = '0; s_rw = 1'b0; s_acked = 1'b0; s_cnt = 0;
    forever begin
      @(negedge clk);
      if (ale === 1'b1) begin s_addr = data; s_rw = rd_wr; end
      if (cs_n === 1'b0) begin
        if (!s_acked) begin
          s_cnt++;
          if (slave_delay != 0 && s_cnt >= slave_delay) begin
            ack_n = 1'b0; s_acked = 1'b1;
            if (s_rw) data_out = smem.exists(s_addr) ? smem[s_addr] : ~s_addr;
            else begin smem[s_addr] = data; data_out = '0; end
          end
        end
      end else begin
        ack_n = 1'b1; s_cnt = 0; s_acked = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

  function automatic logic m_ack(input int m); return m ? m1_ack_n : m0_ack_n; endfunction
  function automatic logic [31:0] m_do(input int m); return m ? m1_data_out : m0_data_out; endfunction
  function automatic logic [31:0] lga(input int i); return (i < lg_addr.size()) ? lg_addr[i] : 32'hxxxx_xxxx; endfunction
  function automatic logic [1:0] lgg(input int i); return (i < lg_gnt.size()) ? lg_gnt[i] : 2'bxx; endfunction

  task automatic clear_log();
    lg_addr.delete(); lg_rw.delete(); lg_gnt.delete(); lg_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; m_ale = '0; m_cs_n = 2'b11;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    clear_log();
  endtask

  task automatic master_txn(input int m, input logic [31:0] a, input logic rw, input logic [31:0] wd,
                            output logic [31:0] rd, output logic ok);
    int n;
    @(negedge clk); m_ale[m] = 1'b1; m_dat[m] = a; m_rw[m] = rw;
    @(negedge clk); ale_cyc[m] = cyc; m_ale[m] = 1'b0; m_dat[m] = rw ? 32'h0 : wd; m_cs_n[m] = 1'b0;
    n = 0;
    while (m_ack(m) !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    ok = (n < 300); rd = m_do(m);
    m_cs_n[m] = 1'b1;
    n = 0;
    while (m_ack(m) !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({ale, cs_n, rd_wr} !== 3'b010) $display("FAIL reset_ctl: got %b want 010", {ale, cs_n, rd_wr}); else passes++;
    checks++; if (data !== 32'h0) $display("FAIL reset_data: got %h want 0", data); else passes++;
    checks++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else passes++;
    checks++; if ({m1_ack_n, m0_ack_n} !== 2'b11) $display("FAIL reset_ack: got %b want 11", {m1_ack_n, m0_ack_n}); else passes++;
    checks++; if ({m1_data_out, m0_data_out} !== 64'h0) $display("FAIL reset_dout: got %h want 0", {m1_data_out, m0_data_out}); else passes++;
    checks++; if (timeout_cnt !== 16'h0) $display("FAIL reset_tocnt: got %h want 0", timeout_cnt); else passes++;
  endtask

  task automatic test_single_read();
    logic [31:0] rd; logic ok;
    do_reset();
    smem[32'h0080_0010] = 32'h1234_5678; slave_delay = 3;
    master_txn(0, 32'h0080_0010, 1'b1, 32'h0, rd, ok);
    checks++; if (ok !== 1'b1) $display("FAIL rd_ack: m0 ack not seen, got %b want 1", ok); else passes++;
    checks++; if (rd !== 32'h1234_5678) $display("FAIL rd_data: got %h want 12345678", rd); else passes++;
    checks++; if (lg_cyc.size() != 1 || lg_cyc[0] - ale_cyc[0] != 2)
      $display("FAIL rd_ale_lat: got %0d entries want 1 with latency 2", lg_cyc.size()); else passes++;
    checks++; if (lga(0) !== 32'h0080_0010) $display("FAIL rd_addr: got %h want 00800010", lga(0)); else passes++;
    checks++; if (lgg(0) !== 2'b01) $display("FAIL rd_grant: got %b want 01", lgg(0)); else passes++;
    checks++; if (m1_data_out !== 32'h0) $display("FAIL rd_m1_hold: got %h want 0", m1_data_out); else passes++;
  endtask

  task automatic test_tie();
    logic [31:0] r0, r1; logic k0, k1;
    do_reset(); slave_delay = 2;
    fork
      master_txn(0, 32'h0000_0200, 1'b1, 32'h0, r0, k0);
      master_txn(1, 32'h0000_0204, 1'b1, 32'h0, r1, k1);
    join
    checks++; if ({k1, k0} !== 2'b11) $display("FAIL tie1_ack: got %b want 11", {k1, k0}); else passes++;
    checks++; if ({lgg(0), lgg(1)} !== 4'b0110) $display("FAIL tie1_order: got %b want 0110", {lgg(0), lgg(1)}); else passes++;
    checks++; if (r1 !== ~32'h0000_0204) $display("FAIL tie1_m1_data: got %h want %h", r1, ~32'h0000_0204); else passes++;
    master_txn(0, 32'h0000_0208, 1'b1, 32'h0, r0, k0);
    clear_log();
    fork
      master_txn(0, 32'h0000_0200, 1'b1, 32'h0, r0, k0);
      master_txn(1, 32'h0000_0204, 1'b1, 32'h0, r1, k1);
    join
    checks++; if ({lgg(0), lgg(1)} !== 4'b1001) $display("FAIL tie2_order: got %b want 1001", {lgg(0), lgg(1)}); else passes++;
  endtask

  task automatic test_write_m1();
    logic [31:0] rd, m0d; logic ok; int n;
    do_reset(); slave_delay = 2; m0d = m0_data_out;
    fork
      master_txn(1, 32'h0000_3000, 1'b0, 32'h0000_0055, rd, ok);
      begin
        n = 0;
        while (cs_n !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        checks++; if (data !== 32'h0000_0055 || cs_n !== 1'b0) $display("FAIL wr_data: got %h cs_n %b want 00000055 cs_n 0", data, cs_n); else passes++;
        checks++; if (m0_ack_n !== 1'b1 || m0_data_out !== m0d) $display("FAIL wr_m0_hold: got ack %b dout %h want 1 %h", m0_ack_n, m0_data_out, m0d); else passes++;
      end
    join
    checks++; if (ok !== 1'b1) $display("FAIL wr_ack: got %b want 1", ok); else passes++;
    master_txn(0, 32'h0000_3000, 1'b1, 32'h0, rd, ok);
    checks++; if (rd !== 32'h0000_0055) $display("FAIL wr_readback: got %h want 00000055", rd); else passes++;
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic ok; int n, k;
    do_reset(); slave_delay = 0; k = 0;
    fork
      master_txn(0, 32'h0000_0400, 1'b1, 32'h0, rd, ok);
      begin
        n = 0;
        while (cs_n !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        while (m0_ack_n !== 1'b0 && k < 100) begin @(negedge clk); k++; end
      end
    join
    checks++; if (k != TO) $display("FAIL to_latency: got %0d want %0d", k, TO); else passes++;
    checks++; if (rd !== TOD || ok !== 1'b1) $display("FAIL to_data: got %h ok %b want %h", rd, ok, TOD); else passes++;
    checks++; if (timeout_cnt !== 16'd1) $display("FAIL to_cnt: got %0d want 1", timeout_cnt); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic ok; int n;
    do_reset(); slave_delay = 0;
    @(negedge clk); m_ale[0] = 1'b1; m_dat[0] = 32'h0000_0500; m_rw[0] = 1'b1;
    @(negedge clk); m_ale[0] = 1'b0; m_dat[0] = '0; m_cs_n[0] = 1'b0;
    n = 0;
    while (cs_n !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if ({cs_n, grant} !== 3'b100) $display("FAIL rstmid_bus: got cs_n %b grant %b want 1 00", cs_n, grant); else passes++;
    checks++; if ({m1_ack_n, m0_ack_n} !== 2'b11) $display("FAIL rstmid_ack: got %b want 11", {m1_ack_n, m0_ack_n}); else passes++;
    m_cs_n[0] = 1'b1; slave_delay = 2;
    master_txn(0, 32'h0000_0504, 1'b1, 32'h0, rd, ok);
    checks++; if (rd !== ~32'h0000_0504 || ok !== 1'b1) $display("FAIL rstmid_next: got %h ok %b want %h", rd, ok, ~32'h0000_0504); else passes++;
  endtask

  task automatic test_ignore_ale();
    int n; logic [31:0] rd;
    do_reset(); slave_delay = 4;
    @(negedge clk); m_ale[0] = 1'b1; m_dat[0] = 32'h0000_0600; m_rw[0] = 1'b1;
    @(negedge clk); m_ale[0] = 1'b0; m_dat[0] = '0; m_cs_n[0] = 1'b0;
    n = 0;
    while (grant !== 2'b01 && n < 100) begin @(negedge clk); n++; end
    m_ale[0] = 1'b1; m_dat[0] = 32'h0000_0700;
    @(negedge clk); m_ale[0] = 1'b0; m_dat[0] = '0;
    n = 0;
    while (m0_ack_n !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    rd = m0_data_out; m_cs_n[0] = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (rd !== ~32'h0000_0600) $display("FAIL ign_data: got %h want %h", rd, ~32'h0000_0600); else passes++;
    checks++; if (lg_addr.size() != 1 || lga(0) !== 32'h0000_0600) $display("FAIL ign_txns: got %0d txns first %h want 1 00000600", lg_addr.size(), lga(0)); else passes++;
    checks++; if (grant !== 2'b00) $display("FAIL ign_idle: got %b want 00", grant); else passes++;
  endtask

  task automatic test_random();
    logic [31:0] a[2], wd[2], r0, r1, rdm, exp;
    logic        rw[2], k0, k1, okm;
    int req, dly, n, m, last_m, ord[2], to_exp;
    do_reset(); smem.delete(); mmem.delete(); last_m = 1; to_exp = 0;
    r0 = '0; r1 = '0; k0 = 1'b0; k1 = 1'b0;
    for (int r = 0; r < 24; r++) begin
      req = $urandom_range(1, 3); dly = $urandom_range(0, 4);
      for (int i = 0; i < 2; i++) begin
        a[i] = 32'h100 + 32'($urandom_range(0, 3)) * 4; rw[i] = 1'($urandom_range(0, 1)); wd[i] = $urandom;
      end
      slave_delay = dly; clear_log();
      fork
        begin if (req[0]) master_txn(0, a[0], rw[0], wd[0], r0, k0); end
        begin if (req[1]) master_txn(1, a[1], rw[1], wd[1], r1, k1); end
      join
      if (req == 3) begin ord[0] = (last_m == 0) ? 1 : 0; ord[1] = 1 - ord[0]; n = 2; end
      else begin ord[0] = (req == 2) ? 1 : 0; ord[1] = ord[0]; n = 1; end
      checks++; if (lg_addr.size() != n) $display("FAIL rnd%0d_count: got %0d want %0d", r, lg_addr.size(), n); else passes++;
      for (int i = 0; i < n; i++) begin
        m = ord[i];
        rdm = m ? r1 : r0; okm = m ? k1 : k0;
        checks++; if (lga(i) !== a[m] || lgg(i) !== 2'(1 << m))
          $display("FAIL rnd%0d_order%0d: got %h/%b want %h/%b", r, i, lga(i), lgg(i), a[m], 2'(1 << m)); else passes++;
        checks++; if (okm !== 1'b1) $display("FAIL rnd%0d_ack%0d: got %b want 1", r, m, okm); else passes++;
        if (dly == 0) to_exp++;
        if (rw[m]) begin
          exp = (dly == 0) ? TOD : (mmem.exists(a[m]) ? mmem[a[m]] : ~a[m]);
          checks++; if (rdm !== exp) $display("FAIL rnd%0d_rd%0d: got %h want %h", r, m, rdm, exp); else passes++;
        end else if (dly != 0) begin
          mmem[a[m]] = wd[m];
        end
      end
      last_m = ord[n - 1];
      checks++; if (timeout_cnt !== 16'(to_exp)) $display("FAIL rnd%0d_tocnt: got %0d want %0d", r, timeout_cnt, to_exp); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_write_m1();
    test_timeout();
    test_reset_mid();
    test_ignore_ale();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
